csr_trap_seq: RTL and testbench

Sequencer between the decode/execute stage and the single-write-port CSR register file. Serialises CSR instructions (CSRRW/CSRRS/CSRRC) and trap entry/return (ECALL/MRET) into one-CSR-per-cycle read/write strobes. Returns the old CSR value for rd and the redirect PC for traps. Its outputs drive the CSR file write port (wen/waddr/wdata) and read port (ren/raddr index); the file's combinational rdata feeds back in.

---
 rtl/csr_trap_pkg.sv | 39 +++
 rtl/csr_addr_dec.sv | 25 ++
 rtl/csr_trap_seq.sv | 216 +++++++++++++++++++++
 tb/tb_csr_trap_seq.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_trap_pkg.sv
// rtl/csr_trap_pkg.sv - shared op codes, CSR map and sequencer states for csr_trap_seq
package csr_trap_pkg;

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd4;
    localparam logic [2:0] OP_MRET  = 3'd5;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    // Read-port indices as laid out in the CSR file
    localparam logic [4:0] IDX_MTVEC   = 5'd0;
    localparam logic [4:0] IDX_MEPC    = 5'd1;
    localparam logic [4:0] IDX_MSTATUS = 5'd2;
    localparam logic [4:0] IDX_MCAUSE  = 5'd3;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CSR_RD,
        ST_CSR_WR,
        ST_EC_MEPC,
        ST_EC_MCAUSE,
        ST_EC_MST_RD,
        ST_EC_MST_WR,
        ST_EC_VEC,
        ST_MR_MST_RD,
        ST_MR_MST_WR,
        ST_MR_EPC,
        ST_ERR
    } state_t;

endpackage

// File: rtl/csr_addr_dec.sv
// rtl/csr_addr_dec.sv - maps a 12-bit CSR address to the CSR file read index
import csr_trap_pkg::*;

module csr_addr_dec (
    input  logic [11:0] addr,
    output logic        hit,
    output logic [4:0]  idx
);

    always_comb begin
        hit = 1'b1;
        idx = IDX_MTVEC;
        case (addr)
            ADDR_MTVEC:   idx = IDX_MTVEC;
            ADDR_MEPC:    idx = IDX_MEPC;
            ADDR_MSTATUS: idx = IDX_MSTATUS;
            ADDR_MCAUSE:  idx = IDX_MCAUSE;
            default: begin
                hit = 1'b0;
                idx = 5'd0;
            end
        endcase
    end

endmodule

// File: rtl/csr_trap_seq.sv
// rtl/csr_trap_seq.sv - serialises CSR ops and ECALL/MRET into single-port CSR accesses
// Optional mstatus read-modify-write on traps: CSR_TRAP_MSTATUS_EN
import csr_trap_pkg::*;

module csr_trap_seq #(
    parameter int               XLEN         = 64,
    parameter logic [XLEN-1:0]  MCAUSE_ECALL = XLEN'(11)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_src,
    input  logic [XLEN-1:0] req_pc,
    output logic            csr_wen,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            csr_ren,
    output logic [4:0]      csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] rd_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] VEC_MASK = ~(XLEN'(3));

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      op_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] src_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] old_q;
    logic [4:0]      idx_q;
    logic            dec_hit;
    logic [4:0]      dec_idx;
    logic            accept;
    logic            capture;
    logic [XLEN-1:0] csr_op_val;

    csr_addr_dec u_addr_dec (
        .addr (req_addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    assign accept = req_valid && (state == ST_IDLE);

`ifdef CSR_TRAP_MSTATUS_EN
    logic [XLEN-1:0] mst_ecall;
    logic [XLEN-1:0] mst_mret;

    always_comb begin
        mst_ecall               = old_q;
        mst_ecall[MSTATUS_MPIE] = old_q[MSTATUS_MIE];
        mst_ecall[MSTATUS_MIE]  = 1'b0;
        mst_mret                = old_q;
        mst_mret[MSTATUS_MIE]   = old_q[MSTATUS_MPIE];
        mst_mret[MSTATUS_MPIE]  = 1'b1;
    end

    assign capture = (state == ST_CSR_RD) || (state == ST_EC_MST_RD) || (state == ST_MR_MST_RD);
`else
    assign capture = (state == ST_CSR_RD);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            addr_q <= '0;
            src_q  <= '0;
            pc_q   <= '0;
            idx_q  <= '0;
            old_q  <= '0;
        end else begin
            if (accept) begin
                op_q   <= req_op;
                addr_q <= req_addr;
                src_q  <= req_src;
                pc_q   <= req_pc;
                idx_q  <= dec_idx;
            end
            if (capture) begin
                old_q <= csr_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: state_nxt = dec_hit ? ST_CSR_RD : ST_ERR;
                        OP_ECALL: state_nxt = ST_EC_MEPC;
`ifdef CSR_TRAP_MSTATUS_EN
                        OP_MRET:  state_nxt = ST_MR_MST_RD;
`else
                        OP_MRET:  state_nxt = ST_MR_EPC;
`endif
                        default:  state_nxt = ST_ERR;
                    endcase
                end
            end
            ST_CSR_RD:    state_nxt = ST_CSR_WR;
            ST_EC_MEPC:   state_nxt = ST_EC_MCAUSE;
`ifdef CSR_TRAP_MSTATUS_EN
            ST_EC_MCAUSE: state_nxt = ST_EC_MST_RD;
            ST_EC_MST_RD: state_nxt = ST_EC_MST_WR;
            ST_EC_MST_WR: state_nxt = ST_EC_VEC;
            ST_MR_MST_RD: state_nxt = ST_MR_MST_WR;
            ST_MR_MST_WR: state_nxt = ST_MR_EPC;
`else
            ST_EC_MCAUSE: state_nxt = ST_EC_VEC;
`endif
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_CSRRS: csr_op_val = old_q | src_q;
            OP_CSRRC: csr_op_val = old_q & ~src_q;
            default:  csr_op_val = src_q;
        endcase
    end

    always_comb begin
        req_ready      = 1'b0;
        csr_wen        = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        csr_ren        = 1'b0;
        csr_raddr      = '0;
        done           = 1'b0;
        err            = 1'b0;
        rd_data        = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_CSR_RD: begin
                csr_ren   = 1'b1;
                csr_raddr = idx_q;
            end
            ST_CSR_WR: begin
                // set/clear with a zero mask must not write (read-only CSRs stay untouched)
                csr_wen   = (op_q == OP_CSRRW) || (src_q != '0);
                csr_waddr = addr_q;
                csr_wdata = csr_op_val;
                done      = 1'b1;
                rd_data   = old_q;
            end
            ST_EC_MEPC: begin
                csr_wen   = 1'b1;
                csr_waddr = ADDR_MEPC;
                csr_wdata = pc_q;
            end
            ST_EC_MCAUSE: begin
                csr_wen   = 1'b1;
                csr_waddr = ADDR_MCAUSE;
                csr_wdata = MCAUSE_ECALL;
            end
`ifdef CSR_TRAP_MSTATUS_EN
            ST_EC_MST_RD, ST_MR_MST_RD: begin
                csr_ren   = 1'b1;
                csr_raddr = IDX_MSTATUS;
            end
            ST_EC_MST_WR: begin
                csr_wen   = 1'b1;
                csr_waddr = ADDR_MSTATUS;
                csr_wdata = mst_ecall;
            end
            ST_MR_MST_WR: begin
                csr_wen   = 1'b1;
                csr_waddr = ADDR_MSTATUS;
                csr_wdata = mst_mret;
            end
`endif
            ST_EC_VEC: begin
                csr_ren        = 1'b1;
                csr_raddr      = IDX_MTVEC;
                done           = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata & VEC_MASK;
            end
            ST_MR_EPC: begin
                csr_ren        = 1'b1;
                csr_raddr      = IDX_MEPC;
                done           = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata;
            end
            ST_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_trap_seq.sv
// tb/tb_csr_trap_seq.sv - randomized self-checking bench for csr_trap_seq with a CSR file model
module tb_csr_trap_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_addr;
    logic [63:0] req_src;
    logic [63:0] req_pc;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata;
    logic        csr_ren;
    logic [4:0]  csr_raddr;
    logic [63:0] csr_rdata;
    logic        done;
    logic        err;
    logic [63:0] rd_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int checks = 0;
    int failures = 0;

    logic [63:0] csr_mem [4];
    logic [63:0] model_csr [4];
    int writes = 0;
    int mst_access = 0;
    int overlap = 0;
    int accepts = 0;
    int dones = 0;

    typedef struct {
        int          lat;
        logic [63:0] rd;
        logic        er;
        logic        rv;
        logic [63:0] rpc;
        logic        wen;
        logic [11:0] waddr;
        logic [63:0] wdata;
        bit          to;
        bit          br;
    } obs_t;

    typedef struct {
        int          lat;
        logic [63:0] rd;
        logic        er;
        logic        rv;
        logic [63:0] rpc;
        int          nw;
        int          nm;
    } exp_t;

    csr_trap_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_src        (req_src),
        .req_pc         (req_pc),
        .csr_wen        (csr_wen),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .csr_ren        (csr_ren),
        .csr_raddr      (csr_raddr),
        .csr_rdata      (csr_rdata),
        .done           (done),
        .err            (err),
        .rd_data        (rd_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic int a2i(input logic [11:0] a);
        case (a)
            12'h305: return 0;
            12'h341: return 1;
            12'h300: return 2;
            12'h342: return 3;
            default: return -1;
        endcase
    endfunction

    always_comb csr_rdata = (csr_raddr < 5'd4) ? csr_mem[csr_raddr[1:0]] : 64'd0;

    always @(posedge clk) begin
        if (csr_wen) begin
            writes++;
            if (a2i(csr_waddr) >= 0) csr_mem[a2i(csr_waddr)] <= csr_wdata;
            if (csr_waddr == 12'h300) mst_access++;
        end
        if (csr_ren && csr_raddr == 5'd2) mst_access++;
        if (req_valid && req_ready) accepts++;
    end

    always @(negedge clk) begin
        if (csr_wen && csr_ren) overlap++;
        if (done) dones++;
    end

    task automatic preset(input int i, input logic [63:0] v);
        csr_mem[i]   = v;
        model_csr[i] = v;
    endtask

    // Spec-level reference: result, latency and CSR side effects of one request
    task automatic model_req(input logic [2:0] op, input logic [11:0] addr, input logic [63:0] src,
                             input logic [63:0] pc, output exp_t e);
        int i;
        logic [63:0] old;
        logic [63:0] ms;
        i = a2i(addr);
        e.lat = 1; e.rd = 0; e.er = 0; e.rv = 0; e.rpc = 0; e.nw = 0; e.nm = 0;
        if (op <= 3'd2) begin
            if (i < 0) begin
                e.er = 1;
            end else begin
                old = model_csr[i];
                e.rd = old;
                e.lat = 2;
                if (op == 3'd0) begin model_csr[i] = src; e.nw = 1; end
                else if (src != 0) begin
                    model_csr[i] = (op == 3'd1) ? (old | src) : (old & ~src);
                    e.nw = 1;
                end
                if (i == 2) e.nm = 1 + e.nw;
            end
        end else if (op == 3'd4) begin
            model_csr[1] = pc;
            model_csr[3] = 64'd11;
            e.nw = 2; e.lat = 3;
`ifdef CSR_TRAP_MSTATUS_EN
            ms = model_csr[2];
            ms[7] = ms[3];
            ms[3] = 1'b0;
            model_csr[2] = ms;
            e.nw = 3; e.lat = 5; e.nm = 2;
`endif
            e.rv = 1;
            e.rpc = model_csr[0] & ~64'd3;
        end else if (op == 3'd5) begin
`ifdef CSR_TRAP_MSTATUS_EN
            ms = model_csr[2];
            ms[3] = ms[7];
            ms[7] = 1'b1;
            model_csr[2] = ms;
            e.nw = 1; e.lat = 3; e.nm = 2;
`endif
            e.rv = 1;
            e.rpc = model_csr[1];
        end else begin
            e.er = 1;
        end
    endtask

    task automatic run_req(input logic [2:0] op, input logic [11:0] addr, input logic [63:0] src,
                           input logic [63:0] pc, input bit hold, output obs_t o);
        int n;
        o.lat = 0; o.rd = 0; o.er = 0; o.rv = 0; o.rpc = 0;
        o.wen = 0; o.waddr = 0; o.wdata = 0; o.to = 1; o.br = 0;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_src = src; req_pc = pc;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        req_op = 3'($urandom); req_addr = 12'($urandom);
        req_src = {$urandom, $urandom}; req_pc = {$urandom, $urandom};
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (req_ready) o.br = 1;
            if (done) begin
                o.lat = c; o.rd = rd_data; o.er = err; o.rv = redirect_valid; o.rpc = redirect_pc;
                o.wen = csr_wen; o.waddr = csr_waddr; o.wdata = csr_wdata; o.to = 0;
                break;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0; req_valid = 0; req_op = 0; req_addr = 0; req_src = 0; req_pc = 0;
        preset(0, 64'h8000_0000); preset(1, 64'h0); preset(2, 64'h8); preset(3, 64'h0);
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if ({csr_wen, csr_ren, done, err, redirect_valid} !== 5'b0) begin failures++;
            $display("FAIL reset_strobes got=%b exp=00000", {csr_wen, csr_ren, done, err, redirect_valid}); end
        checks++; if ({rd_data, redirect_pc, csr_wdata} !== 192'd0) begin failures++;
            $display("FAIL reset_data rd=%h rpc=%h wdata=%h exp=0", rd_data, redirect_pc, csr_wdata); end
        rst_n = 1'b1;
        // Abort an ECALL in its mcause cycle: mepc write stands, mcause never lands
        preset(3, 64'hdead_beef);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd4; req_addr = 12'h0; req_src = 0; req_pc = 64'h8000_1230;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (!(csr_wen === 1'b1 && csr_waddr === 12'h342)) begin failures++;
            $display("FAIL reset_pre_mcause wen=%b waddr=%h exp wen=1 waddr=342", csr_wen, csr_waddr); end
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || {csr_wen, csr_ren, done} !== 3'b0) begin failures++;
            $display("FAIL reset_mid_seq ready=%b wen=%b ren=%b done=%b exp 1/0/0/0", req_ready, csr_wen, csr_ren, done); end
        @(negedge clk);
        rst_n = 1'b1;
        model_csr[1] = 64'h8000_1230;
        checks++; if (csr_mem[1] !== 64'h8000_1230) begin failures++;
            $display("FAIL reset_mepc_kept got=%h exp=80001230", csr_mem[1]); end
        checks++; if (csr_mem[3] !== 64'hdead_beef) begin failures++;
            $display("FAIL reset_mcause_untouched got=%h exp=deadbeef", csr_mem[3]); end
        o.lat = 0;
    endtask

    task automatic test_csr_ops();
        obs_t o;
        exp_t e;
        int w0;
        preset(0, 64'h8000_0000);
        w0 = writes;
        model_req(3'd0, 12'h305, 64'h8000_0100, 0, e);
        run_req(3'd0, 12'h305, 64'h8000_0100, 0, 0, o);
        checks++; if (o.to || o.lat != 2) begin failures++; $display("FAIL csrrw_latency got=%0d to=%0d exp=2", o.lat, o.to); end
        checks++; if (o.rd !== 64'h8000_0000) begin failures++; $display("FAIL csrrw_rd got=%h exp=80000000", o.rd); end
        checks++; if (!(o.wen === 1'b1 && o.waddr === 12'h305 && o.wdata === 64'h8000_0100)) begin failures++;
            $display("FAIL csrrw_write wen=%b addr=%h data=%h exp 1/305/80000100", o.wen, o.waddr, o.wdata); end
        checks++; if (csr_mem[0] !== model_csr[0] || writes - w0 != e.nw) begin failures++;
            $display("FAIL csrrw_file mtvec=%h exp=%h writes=%0d exp=%0d", csr_mem[0], model_csr[0], writes - w0, e.nw); end
        preset(2, 64'h88);
        model_req(3'd1, 12'h300, 64'h0, 0, e);
        run_req(3'd1, 12'h300, 64'h0, 0, 0, o);
        checks++; if (o.lat != 2 || o.wen !== 1'b0 || o.rd !== 64'h88) begin failures++;
            $display("FAIL csrrs_zero lat=%0d wen=%b rd=%h exp 2/0/88", o.lat, o.wen, o.rd); end
        model_req(3'd2, 12'h300, 64'h8, 0, e);
        run_req(3'd2, 12'h300, 64'h8, 0, 0, o);
        checks++; if (o.wen !== 1'b1 || o.wdata !== 64'h80 || o.rd !== 64'h88) begin failures++;
            $display("FAIL csrrc wen=%b wdata=%h rd=%h exp 1/80/88", o.wen, o.wdata, o.rd); end
        checks++; if (csr_mem[2] !== model_csr[2]) begin failures++;
            $display("FAIL csrrc_file got=%h exp=%h", csr_mem[2], model_csr[2]); end
    endtask

    task automatic test_ecall();
        obs_t o;
        exp_t e;
        int w0, m0;
        preset(0, 64'h8000_0203); preset(2, 64'h8);
        w0 = writes; m0 = mst_access;
        model_req(3'd4, 12'h0, 0, 64'h8000_0040, e);
        run_req(3'd4, 12'h0, 0, 64'h8000_0040, 0, o);
        checks++; if (o.to || o.lat != e.lat) begin failures++; $display("FAIL ecall_latency got=%0d exp=%0d", o.lat, e.lat); end
        checks++; if (o.rv !== 1'b1 || o.rpc !== 64'h8000_0200 || o.er !== 1'b0) begin failures++;
            $display("FAIL ecall_redirect rv=%b rpc=%h err=%b exp 1/80000200/0", o.rv, o.rpc, o.er); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (csr_mem[k] !== model_csr[k]) begin failures++;
                $display("FAIL ecall_csr%0d got=%h exp=%h", k, csr_mem[k], model_csr[k]); end
        end
        checks++; if (writes - w0 != e.nw || mst_access - m0 != e.nm) begin failures++;
            $display("FAIL ecall_access writes=%0d exp=%0d mst=%0d exp=%0d", writes - w0, e.nw, mst_access - m0, e.nm); end
    endtask

    task automatic test_mret();
        obs_t o;
        exp_t e;
        int m0;
        preset(1, 64'h8000_0044); preset(2, 64'h80);
        m0 = mst_access;
        model_req(3'd5, 12'h0, 0, 0, e);
        run_req(3'd5, 12'h0, 0, 0, 0, o);
        checks++; if (o.to || o.lat != e.lat) begin failures++; $display("FAIL mret_latency got=%0d exp=%0d", o.lat, e.lat); end
        checks++; if (o.rv !== 1'b1 || o.rpc !== 64'h8000_0044) begin failures++;
            $display("FAIL mret_redirect rv=%b rpc=%h exp 1/80000044", o.rv, o.rpc); end
        checks++; if (csr_mem[2] !== model_csr[2] || mst_access - m0 != e.nm) begin failures++;
            $display("FAIL mret_mstatus got=%h exp=%h mst=%0d exp=%0d", csr_mem[2], model_csr[2], mst_access - m0, e.nm); end
    endtask

    task automatic test_illegal();
        obs_t o;
        int w0, a0;
        logic [11:0] ad [2];
        logic [2:0]  op [2];
        ad[0] = 12'h305; op[0] = 3'd3;
        ad[1] = 12'h7C0; op[1] = 3'd0;
        for (int k = 0; k < 2; k++) begin
            w0 = writes; a0 = accepts;
            run_req(op[k], ad[k], 64'h1234, 0, 1, o);
            checks++; if (o.to || o.lat != 1 || o.er !== 1'b1 || o.rd !== 64'd0) begin failures++;
                $display("FAIL illegal%0d lat=%0d err=%b rd=%h exp 1/1/0", k, o.lat, o.er, o.rd); end
            checks++; if (writes != w0 || accepts - a0 != 1 || o.br) begin failures++;
                $display("FAIL illegal%0d_side writes=%0d accepts=%0d busy_ready=%0d exp 0/1/0", k, writes - w0, accepts - a0, o.br); end
        end
    endtask

    task automatic test_back_to_back();
        int a0, d0;
        a0 = accepts; d0 = dones;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_addr = 12'h305; req_src = 64'h4000_0000; req_pc = 0;
        repeat (12) @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        model_csr[0] = 64'h4000_0000;
        checks++; if (accepts - a0 != 4 || dones - d0 != 4) begin failures++;
            $display("FAIL back_to_back accepts=%0d dones=%0d exp 4/4", accepts - a0, dones - d0); end
        checks++; if (csr_mem[0] !== model_csr[0]) begin failures++;
            $display("FAIL back_to_back_mtvec got=%h exp=%h", csr_mem[0], model_csr[0]); end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        int w0, m0;
        logic [2:0]  op;
        logic [11:0] ad;
        logic [63:0] src, pc;
        logic [2:0]  optab [10];
        logic [11:0] adtab [4];
        optab = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};
        adtab = '{12'h300, 12'h305, 12'h341, 12'h342};
        for (int n = 0; n < 60; n++) begin
            op  = optab[$urandom_range(0, 9)];
            ad  = ($urandom_range(0, 4) == 0) ? 12'($urandom) : adtab[$urandom_range(0, 3)];
            src = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            pc  = {$urandom, $urandom};
            w0 = writes; m0 = mst_access;
            model_req(op, ad, src, pc, e);
            run_req(op, ad, src, pc, $urandom_range(0, 1) == 1, o);
            checks++; if (o.to || o.lat != e.lat || o.er !== e.er || o.br) begin failures++;
                $display("FAIL rand%0d_ctl op=%0d lat=%0d exp=%0d err=%b exp=%b to=%0d br=%0d", n, op, o.lat, e.lat, o.er, e.er, o.to, o.br); end
            checks++; if (o.rd !== e.rd || o.rv !== e.rv || o.rpc !== e.rpc) begin failures++;
                $display("FAIL rand%0d_data op=%0d rd=%h exp=%h rv=%b exp=%b rpc=%h exp=%h", n, op, o.rd, e.rd, o.rv, e.rv, o.rpc, e.rpc); end
            checks++; if (writes - w0 != e.nw || mst_access - m0 != e.nm) begin failures++;
                $display("FAIL rand%0d_access writes=%0d exp=%0d mst=%0d exp=%0d", n, writes - w0, e.nw, mst_access - m0, e.nm); end
            for (int k = 0; k < 4; k++) begin
                checks++; if (csr_mem[k] !== model_csr[k]) begin failures++;
                    $display("FAIL rand%0d_csr%0d got=%h exp=%h", n, k, csr_mem[k], model_csr[k]); end
            end
        end
        checks++; if (overlap != 0) begin failures++; $display("FAIL wen_ren_overlap got=%0d exp=0", overlap); end
    endtask

    initial begin
        test_reset();
        test_csr_ops();
        test_ecall();
        test_mret();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
